booth3_pp_accumulator: RTL and testbench
========================================

Name: booth3_pp_accumulator

Overview:
- Consumer end of the radix-8 Booth partial-product interface.
- Accepts one partial-product row per handshake, as produced by the 8x8 signed Booth-3 row generator (pp, sout, eout):
  - reconstructs each row's signed value from its one's-complement form plus sign correction;
  - weights row i by 2^(3i) and accumulates;
  - presents the 16-bit signed product after the last row.
- Sits between the row generator and the product register / downstream consumer.

Parameters:
- ROWS, 3, rows per product (8-bit signed multiplier, radix-8)
- PP_W, 10, width of pp input
- OUT_W, 16, product width
- SHIFT, 3, weight step between consecutive rows (bits)

Ports:
- CLK  input  1  clock, all state on rising edge
- RST  input  1  asynchronous, active-low reset
- clear  input  1  synchronous abort; drops the partial accumulation
- in_valid  input  1  row present
- in_ready  output  1  row can be accepted
- pp  input  PP_W  one's-complement partial-product row
- sout  input  1  row negate flag (+1 LSB correction)
- eout  input  1  inverted sign of the row (sign-extension bit)
- out_valid  output  1  product valid
- out_ready  input  1  downstream accepts product
- prod  output  OUT_W  signed product

Behaviour:
- Reset (RST=0, asynchronous): state=ACC, row_cnt=0, acc=0, out_valid=0, prod=0, in_ready=1 once RST deasserts.
- Row value: R = signext_to_OUT_W({~eout, pp}) + sout, an 11-bit two's-complement value plus correction. Range covers -4x for x=-128, i.e. +512.
- Row acceptance:
  - a row is accepted on a cycle with in_valid & in_ready;
  - on accept: acc <= acc + (R << SHIFT*row_cnt), with arithmetic mod 2^OUT_W;
  - row_cnt increments on each accept.
- Row order: row 0 (LSB group) first; no reordering.
- States:
  - ACC: in_ready=1, out_valid=0. On the accept with row_cnt==ROWS-1: prod <= final sum (acc + weighted R), state goes to DONE.
  - DONE: in_ready=0, out_valid=1, prod held stable. On out_valid & out_ready: acc=0, row_cnt=0, state goes to ACC.
- Latency: out_valid rises the cycle after the third row is accepted. Back-to-back throughput is one product per ROWS+1 cycles when out_ready is held high.
- Backpressure: prod and out_valid hold indefinitely while out_ready=0. in_valid/pp are ignored while in DONE; the source must hold its data.
- clear=1:
  - next edge: acc=0, row_cnt=0, state=ACC, out_valid=0;
  - takes priority over a simultaneous row accept or output handshake; both are discarded;
  - prod keeps its last value.
- Reset mid-operation discards all partial state; no product is emitted for the interrupted sequence.
- Overflow: OUT_W=16 is exact for all 8x8 signed operands (max 16384 for -128 x -128); no saturation is required.
- in_ready depends only on state, not on in_valid. No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package holds:
  - constants PP_W=10, OUT_W=16, ROWS=3, SHIFT=3;
  - state enum {ACC, DONE};
  - function row_value(pp, sout, eout) returning the OUT_W signed R.
- One natural sub-module: booth3_row_weight (combinational). Inputs pp, sout, eout, row_cnt; output R << 3*row_cnt. It is unit-testable against the row generator's outputs.

Test Plan:
1. 5 x 3 rows: (pp=0x00F, s=0, e=1), (0x000, 0, 1), (0x000, 0, 1), out_ready=1 -> out_valid one cycle after the third accept, prod=0x000F, then in_ready=1 on the following cycle.
2. 5 x -1 rows: (0x3FA, 1, 0), (0x3FF, 1, 0), (0x3FF, 1, 0) -> prod=0xFFFB (-5). Negative-zero rows contribute 0.
3. -128 x -128 rows: (0x000, 0, 1), (0x000, 0, 1), (0x0FF, 1, 1) -> prod=0x4000.
4. Backpressure: run case 1 with out_ready=0 for 5 cycles and in_valid held high with new data -> prod stays 0x000F, in_ready=0 throughout. Raise out_ready -> one handshake, then row 0 of the next product is accepted.
5. clear after two rows of case 2, then feed case 3 fully -> prod=0x4000, with no contamination from case 2.
6. Assert RST=0 asynchronously mid-cycle after one accepted row -> out_valid=0 and in_ready=1 immediately after release. A subsequent case 1 gives 0x000F.

Source files
------------

// File: rtl/booth3_pp_accumulator_pkg.sv
// ============================================================================
// booth3_pp_accumulator_pkg
// Shared constants, state encoding and row reconstruction for the accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package booth3_pp_accumulator_pkg;

  localparam int PP_W  = 10;
  localparam int OUT_W = 16;
  localparam int ROWS  = 3;
  localparam int SHIFT = 3;
  localparam int CNT_W = $clog2(ROWS + 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // {~eout, pp} is the row in 11-bit two's complement; sout adds the +1 that
  // turns the one's-complement negation into a true negation.
  function automatic logic signed [OUT_W-1:0] row_value(
    input logic [PP_W-1:0] pp,
    input logic            sout,
    input logic            eout
  );
    logic [PP_W:0] w_ext;
    w_ext = {~eout, pp};
    return {{(OUT_W-PP_W-1){w_ext[PP_W]}}, w_ext} + OUT_W'(sout);
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth3_row_weight.sv
// ============================================================================
// booth3_row_weight
// Reconstructs one Booth-3 row and weights it by 2^(SHIFT*row_cnt).
// Revision: 1.0
// ============================================================================
`default_nettype none

module booth3_row_weight
  import booth3_pp_accumulator_pkg::*;
(
  input  logic [PP_W-1:0]  i_pp,
  input  logic             i_sout,
  input  logic             i_eout,
  input  logic [CNT_W-1:0] i_row_cnt,
  output logic [OUT_W-1:0] o_weighted
);

  logic [OUT_W-1:0] w_row;
  logic [3:0]       w_shamt;

  always_comb begin
    w_row      = row_value(i_pp, i_sout, i_eout);
    w_shamt    = 4'(i_row_cnt) * 4'(SHIFT);
    o_weighted = w_row << w_shamt;
  end

endmodule

`default_nettype wire

// File: rtl/booth3_pp_accumulator.sv
// ============================================================================
// booth3_pp_accumulator
// Accumulates ROWS weighted Booth-3 partial-product rows into a signed product.
// Revision: 1.0
// ============================================================================
`default_nettype none

module booth3_pp_accumulator
  import booth3_pp_accumulator_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  pp,
  input  logic             sout,
  input  logic             eout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] prod
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_row_cnt;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_prod;
  logic [OUT_W-1:0] w_weighted;
  logic [OUT_W-1:0] w_sum;
  logic             w_accept;
  logic             w_last;
  logic             w_release;

  booth3_row_weight u_row_weight (
    .i_pp       (pp),
    .i_sout     (sout),
    .i_eout     (eout),
    .i_row_cnt  (r_row_cnt),
    .o_weighted (w_weighted)
  );

  assign w_accept  = in_valid && (r_state == ACC);
  assign w_last    = (r_row_cnt == CNT_W'(ROWS - 1));
  assign w_release = out_ready && (r_state == DONE);
  assign w_sum     = r_acc + w_weighted;

  // Handshake outputs come from state alone, so no input-to-output paths exist.
  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == DONE);
  assign prod      = r_prod;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_accept && w_last) w_state_nxt = DONE;
      DONE:    if (w_release)          w_state_nxt = ACC;
      default:                         w_state_nxt = ACC;
    endcase
    if (clear) w_state_nxt = ACC;
  end

  // clear outranks both the row accept and the output handshake; prod survives it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_row_cnt <= '0;
      r_acc     <= '0;
      r_prod    <= '0;
    end else if (clear || w_release) begin
      r_row_cnt <= '0;
      r_acc     <= '0;
    end else if (w_accept) begin
      r_row_cnt <= r_row_cnt + 1'b1;
      r_acc     <= w_sum;
      if (w_last) r_prod <= w_sum;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth3_pp_accumulator.sv
// ============================================================================
// tb_booth3_pp_accumulator
// Self-checking bench: integer-level product model plus directed literal cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_booth3_pp_accumulator;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  pp = '0;
  logic        sout = 1'b0;
  logic        eout = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] prod;

  int checks = 0;
  int errors = 0;

  booth3_pp_accumulator dut (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp        (pp),
    .sout      (sout),
    .eout      (eout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 CLK = ~CLK;

  // Signed row value times its radix-8 weight, in plain integer arithmetic.
  function automatic int row_term(input logic [9:0] p, input logic s, input logic e, input int k);
    int v;
    v = int'({~e, p});
    if (v >= 1024) v = v - 2048;
    v = v + int'(s);
    return v * (8 ** k);
  endfunction

  bit          m_done;
  int          m_cnt;
  int          m_sum;
  logic [15:0] m_prod;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_sum  <= 0;
      m_prod <= '0;
    end else if (clear) begin
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_sum  <= 0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done <= 1'b0;
        m_cnt  <= 0;
        m_sum  <= 0;
      end
    end else if (in_valid) begin
      m_sum <= m_sum + row_term(pp, sout, eout, m_cnt);
      m_cnt <= m_cnt + 1;
      if (m_cnt == 2) begin
        m_done <= 1'b1;
        m_prod <= 16'(m_sum + row_term(pp, sout, eout, m_cnt));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    if (RST) begin
      check("model in_ready", 32'(in_ready), 32'(!m_done));
      check("model out_valid", 32'(out_valid), 32'(m_done));
      check("model prod", 32'(prod), 32'(m_prod));
    end else begin
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset prod", 32'(prod), 32'd0);
    end
  endtask

  task automatic send_row(input logic [9:0] p, input logic s, input logic e);
    bit taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    pp       = p;
    sout     = s;
    eout     = e;
    for (int i = 0; i < 40 && !taken; i++) begin
      taken = in_ready;
      tick();
    end
    if (!taken) check("row accept timeout", 32'd0, 32'd1);
  endtask

  task automatic send_case(input int which);
    case (which)
      1: begin send_row(10'h00F, 0, 1); send_row(10'h000, 0, 1); send_row(10'h000, 0, 1); end
      2: begin send_row(10'h3FA, 1, 0); send_row(10'h3FF, 1, 0); send_row(10'h3FF, 1, 0); end
      default: begin send_row(10'h000, 0, 1); send_row(10'h000, 0, 1); send_row(10'h0FF, 1, 1); end
    endcase
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("reset in_ready", 32'(in_ready), 32'd1);
    #3 RST = 1'b1;
    tick();

    // Case 1: 5 x 3
    out_ready = 1'b1;
    send_case(1);
    check("c1 out_valid", 32'(out_valid), 32'd1);
    check("c1 prod", 32'(prod), 32'h000F);
    tick();
    check("c1 in_ready after", 32'(in_ready), 32'd1);

    // Case 2: 5 x -1
    send_case(2);
    check("c2 prod", 32'(prod), 32'hFFFB);
    tick();

    // Case 3: -128 x -128
    send_case(3);
    check("c3 prod", 32'(prod), 32'h4000);
    tick();

    // Backpressure with a new row held at the input
    out_ready = 1'b0;
    send_case(1);
    in_valid = 1'b1; pp = 10'h000; sout = 1'b0; eout = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp prod", 32'(prod), 32'h000F);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp released in_ready", 32'(in_ready), 32'd1);
    send_case(3);
    check("bp next prod", 32'(prod), 32'h4000);
    tick();

    // clear after two rows of case 2
    send_row(10'h3FA, 1, 0);
    send_row(10'h3FF, 1, 0);
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear out_valid", 32'(out_valid), 32'd0);
    send_case(3);
    check("post-clear prod", 32'(prod), 32'h4000);
    tick();

    // Asynchronous reset after one accepted row
    send_row(10'h00F, 0, 1);
    in_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst prod", 32'(prod), 32'd0);
    tick();
    #3 RST = 1'b1;
    tick();
    check("post-rst in_ready", 32'(in_ready), 32'd1);
    send_case(1);
    check("post-rst prod", 32'(prod), 32'h000F);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      pp        = 10'($urandom);
      sout      = 1'($urandom);
      eout      = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 31) == 0);
      tick();
    end
    clear    = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
